// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle for the MEM-stage data memory.
// The master drives requests; the slave returns read data and status.
interface data_mem_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              memRead;
  logic              memWrite;
  logic              size;
  logic              signExt;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] dataIn;
  logic [DATA_W-1:0] dataOut;
  logic              dataValid;
  logic              busy;
  logic              misaligned;

  modport master (
    output memRead, memWrite, size, signExt,
    output address, dataIn,
    input  dataOut, dataValid, busy, misaligned
  );

  modport slave (
    input  memRead, memWrite, size, signExt,
    input  address, dataIn,
    output dataOut, dataValid, busy, misaligned
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Big-endian byte-addressed data memory with self-clear after reset.
// Misaligned word accesses take a second SPLIT cycle on the next word.
module data_mem_ctrl #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH_BYTES = 4096
) (
  input logic           clk,
  input logic           rst,
  data_mem_ctrl_if.slave bus
);
  localparam int BYTES       = DATA_W / 8;
  localparam int DEPTH_WORDS = DEPTH_BYTES / BYTES;
  localparam int OFF_W       = $clog2(BYTES);
  localparam int BA_W        = $clog2(DEPTH_BYTES);
  localparam int WA_W        = BA_W - OFF_W;

  typedef enum logic [1:0] {CLEAR, IDLE, SPLIT} state_t;

  state_t state, nxt;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic [WA_W-1:0]   clr_ptr, r_idx, idx, in_idx;
  logic [OFF_W-1:0]  r_off, in_off;
  logic [DATA_W-1:0] r_data, rbuf, rword, wdata;
  logic [DATA_W-1:0] split_word, rd_val;
  logic [BYTES-1:0]  lane_we;
  logic [7:0]        rbyte;
  logic              r_wr, r_rd;
  logic              accept, rd_go, mis;

  function automatic logic [7:0] lane(
    input logic [DATA_W-1:0] w,
    input int                k
  );
    return w[DATA_W-1-8*k -: 8];
  endfunction

  assign in_idx   = bus.address[BA_W-1:OFF_W];
  assign in_off   = bus.address[OFF_W-1:0];
  assign mis      = bus.size && (in_off != '0);
  assign rword    = mem[idx];
  assign bus.busy = (state != IDLE);

  generate
    if (ADDR_W > BA_W) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^bus.address[ADDR_W-1:BA_W];
    end
  endgenerate

  // Data byte j lands in lane (j + off) mod BYTES for both halves.
  always_comb begin
    nxt     = state;
    idx     = in_idx;
    lane_we = '0;
    wdata   = '0;
    accept  = 1'b0;
    rd_go   = 1'b0;
    unique case (state)
      CLEAR: begin
        idx     = clr_ptr;
        lane_we = '1;
        if (clr_ptr == WA_W'(DEPTH_WORDS - 1))
          nxt = IDLE;
      end
      IDLE: begin
        accept = bus.memRead || bus.memWrite;
        rd_go  = bus.memRead && !bus.memWrite;
        if (bus.memWrite) begin
          for (int l = 0; l < BYTES; l++) begin
            if (!bus.size && OFF_W'(l) == in_off) begin
              lane_we[l] = 1'b1;
              wdata[DATA_W-1-8*l -: 8] = bus.dataIn[7:0];
            end else if (bus.size && OFF_W'(l) >= in_off) begin
              lane_we[l] = 1'b1;
              wdata[DATA_W-1-8*l -: 8] =
                lane(bus.dataIn, int'(OFF_W'(l) - in_off));
            end
          end
        end
        if (accept && mis)
          nxt = SPLIT;
      end
      SPLIT: begin
        idx = r_idx + WA_W'(1);
        if (r_wr) begin
          for (int l = 0; l < BYTES; l++) begin
            if (OFF_W'(l) < r_off) begin
              lane_we[l] = 1'b1;
              wdata[DATA_W-1-8*l -: 8] =
                lane(r_data, int'(OFF_W'(l) - r_off));
            end
          end
        end
        nxt = IDLE;
      end
      default: nxt = CLEAR;
    endcase
  end

  always_comb begin
    rbyte  = lane(rword, int'(in_off));
    rd_val = bus.size ? rword
           : {{(DATA_W-8){bus.signExt & rbyte[7]}}, rbyte};
    split_word = '0;
    for (int j = 0; j < BYTES; j++) begin
      if (j + int'(r_off) < BYTES)
        split_word[DATA_W-1-8*j -: 8] = lane(rbuf, j + int'(r_off));
      else
        split_word[DATA_W-1-8*j -: 8] =
          lane(rword, j + int'(r_off) - BYTES);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state <= nxt;
      if (state == CLEAR)
        clr_ptr <= clr_ptr + WA_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx          <= '0;
      r_off          <= '0;
      r_data         <= '0;
      r_wr           <= 1'b0;
      r_rd           <= 1'b0;
      rbuf           <= '0;
      bus.dataOut    <= '0;
      bus.dataValid  <= 1'b0;
      bus.misaligned <= 1'b0;
    end else begin
      bus.dataValid  <= 1'b0;
      bus.misaligned <= 1'b0;
      if (accept) begin
        r_idx          <= in_idx;
        r_off          <= in_off;
        r_data         <= bus.dataIn;
        r_wr           <= bus.memWrite;
        r_rd           <= rd_go;
        rbuf           <= rword;
        bus.misaligned <= mis;
        if (rd_go && !mis) begin
          bus.dataOut   <= rd_val;
          bus.dataValid <= 1'b1;
        end
      end
      if (state == SPLIT && r_rd) begin
        bus.dataOut   <= split_word;
        bus.dataValid <= 1'b1;
      end
    end
  end

  // Storage is not reset; the CLEAR sweep zeroes it instead.
  always_ff @(posedge clk) begin
    for (int l = 0; l < BYTES; l++) begin
      if (lane_we[l])
        mem[idx][DATA_W-1-8*l -: 8] <= wdata[DATA_W-1-8*l -: 8];
    end
  end
endmodule
